// File: rtl/game_pkg.sv
// Shared game definitions: move range, debounce default, enter FSM encoding
// and the move-legality helper used by the move entry logic.
package game_pkg;

  localparam int MOVE_W    = 4;
  localparam int NUM_SLOTS = 8;

  localparam logic [MOVE_W-1:0] MIN_MOVE = 4'd1;
  localparam logic [MOVE_W-1:0] MAX_MOVE = 4'd9;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    WAIT_PRESS      = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } enter_state_e;

  // Observation bundle for both debouncers.
  typedef struct packed {
    enter_state_e enter_state;
    enter_state_e newgame_state;
    logic         enter_level_L;
  } move_dbg_t;

  typedef logic [NUM_SLOTS-1:0][MOVE_W-1:0] slots_t;

  // A move is legal when it is in range and no occupied slot already holds it.
  function automatic logic move_legal(input logic [MOVE_W-1:0] mv,
                                      input slots_t            taken);
    logic ok;
    ok = (mv >= MIN_MOVE) && (mv <= MAX_MOVE);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((taken[i] != '0) && (taken[i] == mv)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus a four-state press/release debouncer for one
// active-low button; reports the debounced level and a one-cycle press event.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         raw_L,
  input  logic         clear,
  output logic         level_L,
  output logic         press,
  output enter_state_e state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    sync_q;
  logic          sample_L;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [CW-1:0] count_inc;
  enter_state_e  state_n;

  // Only sync_q[1] is allowed to reach the debounce logic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw_L};
    end
  end

  assign sample_L  = sync_q[1];
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WAIT_PRESS;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    if (clear) begin
      state_n = WAIT_PRESS;
      count_n = '0;
    end else begin
      unique case (state)
        WAIT_PRESS: begin
          if (!sample_L) begin
            if (CNT_ONE >= CNT_MAX) begin
              state_n = HELD;
              count_n = CNT_MAX;
            end else begin
              state_n = CONFIRM_PRESS;
              count_n = CNT_ONE;
            end
          end
        end
        CONFIRM_PRESS: begin
          if (sample_L) begin
            state_n = WAIT_PRESS;
            count_n = '0;
          end else if (count_inc == CNT_MAX) begin
            state_n = HELD;
            count_n = CNT_MAX;
          end else begin
            count_n = count_inc;
          end
        end
        HELD: begin
          if (sample_L) begin
            if (CNT_ONE >= CNT_MAX) begin
              state_n = WAIT_PRESS;
              count_n = '0;
            end else begin
              state_n = CONFIRM_RELEASE;
              count_n = CNT_ONE;
            end
          end
        end
        CONFIRM_RELEASE: begin
          if (!sample_L) begin
            state_n = HELD;
            count_n = CNT_MAX;
          end else if (count_inc == CNT_MAX) begin
            state_n = WAIT_PRESS;
            count_n = '0;
          end else begin
            count_n = count_inc;
          end
        end
        default: begin
          state_n = WAIT_PRESS;
          count_n = '0;
        end
      endcase
    end
  end

  // Press fires on the edge that first enters HELD from the unpressed side.
  always_comb begin
    level_L = !((state == HELD) || (state == CONFIRM_RELEASE));
    press   = (state_n == HELD) &&
              ((state == WAIT_PRESS) || (state == CONFIRM_PRESS));
  end

  count_saturates: assert property (@(posedge clock) disable iff (reset)
    count <= CNT_MAX);

endmodule

// File: rtl/move_entry.sv
// Human move entry: debounces the enter and new-game buttons, checks move
// legality on each confirmed press and drives the strobe/error outputs.
module move_entry
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter_raw_L,
  input  logic              newGame_raw_L,
  input  logic [MOVE_W-1:0] hMove_sw,
  input  logic [MOVE_W-1:0] h3,
  input  logic [MOVE_W-1:0] h2,
  input  logic [MOVE_W-1:0] h1,
  input  logic [MOVE_W-1:0] h0,
  input  logic [MOVE_W-1:0] c3,
  input  logic [MOVE_W-1:0] c2,
  input  logic [MOVE_W-1:0] c1,
  input  logic [MOVE_W-1:0] c0,
  output logic              enter_L,
  output logic              newGame_L,
  output logic [MOVE_W-1:0] hMove,
  output logic              moveErr,
  output move_dbg_t         dbg
);

  logic         enter_press;
  logic         enter_level_L;
  enter_state_e enter_state;
  logic         ng_press;
  logic         ng_level_L;
  enter_state_e ng_state;
  logic         ng_active;
  logic         accept;
  logic         legal;

  // A held new-game button parks the enter debouncer in WAIT_PRESS.
  assign ng_active = !newGame_L;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clock  (clock),
    .reset  (reset),
    .raw_L  (enter_raw_L),
    .clear  (ng_active),
    .level_L(enter_level_L),
    .press  (enter_press),
    .state  (enter_state)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_newgame_db (
    .clock  (clock),
    .reset  (reset),
    .raw_L  (newGame_raw_L),
    .clear  (1'b0),
    .level_L(ng_level_L),
    .press  (ng_press),
    .state  (ng_state)
  );

  assign newGame_L = ng_level_L;

  // enter_L is a one-cycle low strobe; hMove is valid whenever it is low and
  // keeps that value until the next accepted move. No back-pressure exists.
  assign accept = enter_press && !ng_press;
  assign legal  = move_legal(hMove_sw, {h3, h2, h1, h0, c3, c2, c1, c0});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enter_L <= 1'b1;
      hMove   <= '0;
      moveErr <= 1'b0;
    end else begin
      enter_L <= 1'b1;
      if (ng_active) begin
        moveErr <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          enter_L <= 1'b0;
          hMove   <= hMove_sw;
          moveErr <= 1'b0;
        end else begin
          moveErr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    dbg.enter_state   = enter_state;
    dbg.newgame_state = ng_state;
    dbg.enter_level_L = enter_level_L;
  end

  strobe_one_cycle: assert property (@(posedge clock) disable iff (reset)
    !enter_L |=> enter_L);

  no_strobe_in_new_game: assert property (@(posedge clock) disable iff (reset)
    !newGame_L |-> enter_L);

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a press or a release.
REQ-002 clock  input  1  single system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enter_raw_L  input  1  raw active-low enter button, asynchronous to clock.
REQ-005 newGame_raw_L  input  1  raw active-low new-game button, asynchronous to clock.
REQ-006 hMove_sw  input  4  raw human move switches.
REQ-007 h3,h2,h1,h0,c3,c2,c1,c0  input  4 each  moves already taken, fed back from the game FSM; 0 means an empty slot.
REQ-008 enter_L  output  1  active-low, one-cycle accepted-move strobe to the game FSM.
REQ-009 newGame_L  output  1  debounced active-low new-game level to the game FSM.
REQ-010 hMove  output  4  registered move value, stable while enter_L is low and held until the next accepted move.
REQ-011 moveErr  output  1  sticky flag: the last confirmed press carried an illegal move.

Function
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Enter FSM states SHALL be WAIT_PRESS, CONFIRM_PRESS, HELD and CONFIRM_RELEASE.
REQ-014 WAIT_PRESS: a synchronized low SHALL move the FSM to CONFIRM_PRESS, with count=1.
REQ-015 CONFIRM_PRESS: each low sample SHALL increment count; a high sample SHALL return the FSM to WAIT_PRESS with count=0 (bounce); count==DEBOUNCE_CYCLES SHALL move the FSM to HELD.
REQ-016 On the WAIT_PRESS/CONFIRM_PRESS to HELD transition edge, the block SHALL evaluate legality: hMove_sw in 1..9, and hMove_sw not equal to any nonzero h*/c* input.
REQ-017 Legal move: hMove SHALL load hMove_sw, enter_L SHALL be low for exactly the one following cycle, and moveErr SHALL clear.
REQ-018 Illegal move: enter_L SHALL stay high, hMove SHALL hold its value, and moveErr SHALL set.
REQ-019 HELD: the block SHALL issue no further strobe, however long the button is held; a high sample SHALL move the FSM to CONFIRM_RELEASE with count=1.
REQ-020 CONFIRM_RELEASE: a low sample SHALL return the FSM to HELD; count==DEBOUNCE_CYCLES high samples SHALL return it to WAIT_PRESS.
REQ-021 Latency: raw low first sampled at edge k, held stable, SHALL give enter_L low after edge k+1+DEBOUNCE_CYCLES and high again one edge later.
REQ-022 The newGame path SHALL use the same synchronize+debounce rule; newGame_L SHALL follow the debounced level (no pulse shaping).
REQ-023 While debounced newGame_L is low, moveErr SHALL clear, the enter FSM SHALL be forced to WAIT_PRESS, and enter_L SHALL be held high.
REQ-024 If the newGame press and the enter acceptance occur on the same edge, newGame SHALL win: no strobe, and hMove is unchanged.
REQ-025 The count register SHALL saturate at DEBOUNCE_CYCLES and never wrap; its width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-026 Reset SHALL force, asynchronously: enter_L=1, newGame_L=1, hMove=0, moveErr=0, FSM=WAIT_PRESS, counts=0, synchronizer flops=1.
REQ-027 Reset asserted mid-debounce or mid-strobe SHALL abort without emitting a strobe; after reset releases, a press SHALL need full re-confirmation.

Structure
REQ-028 Shared package game_pkg SHALL hold MIN_MOVE=1, MAX_MOVE=9, DEBOUNCE_CYCLES_DEFAULT and the enter FSM state enum.
REQ-029 Sub-module btn_debounce (synchronizer + counter + debounced level) SHALL be instantiated once per button; move_entry SHALL add the strobe, legality and error logic.

Verification
REQ-030 Clean press, N=4, hMove_sw=6, all slots 0, raw low at edge 0 -> enter_L low only after edge 5, hMove=6, moveErr=0.
REQ-031 Bounce: raw low for 2 cycles, high 1, then low steady -> exactly one strobe, 4+2 cycles after the final low sample.
REQ-032 Illegal: h0=5, hMove_sw=5 -> no strobe, moveErr=1; then hMove_sw=9 pressed -> strobe, hMove=9, moveErr=0.
REQ-033 Out of range: hMove_sw=0 or 12 -> no strobe, moveErr=1; button held 50 cycles -> still no strobe.
REQ-034 newGame held low while enter is pressed -> enter_L stays high, moveErr=0, newGame_L low after debounce latency.
REQ-035 Reset pulse during CONFIRM_PRESS -> all outputs at reset values and no strobe; a subsequent full press -> one strobe.
